// File: rtl/uart_tx_frame64_pkg.sv
// Shared definitions for the 64-bit UART frame transmitter and its matching receiver.
package uart_tx_frame64_pkg;

  // Transmit FSM states, one per part of a character plus the optional gap
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } tx_state_t;

  // One start bit, eight data bits and one stop bit per character
  localparam int UART_BITS_PER_CHAR = 10;

  // A 64-bit block is carried as eight bytes
  localparam int FRAME_BYTES = 8;

  // Index of the final byte of a frame, as held by the 3-bit byte counter
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  // Terminal value of the 4-bit gap counter; a zero gap never reaches the gap state
  function automatic logic [3:0] gapLast(input int gapBits);
    if (gapBits > 0) begin
      return 4'(gapBits - 1);
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BPS_CNT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic i_clear,
  output logic o_bitEnd
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  logic [CNT_W-1:0] r_count;

  // Free-running bit counter, restarted whenever the FSM enters a new state
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_count <= '0;
    end else if (i_clear || (r_count == CNT_LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_bitEnd = (r_count == CNT_LAST) && !i_clear;

endmodule

// File: rtl/uart_tx_frame64.sv
// Serialises a 64-bit block as eight 8N1 UART characters, most significant byte first.
module uart_tx_frame64
  import uart_tx_frame64_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int UART_BPS = 115200,
  parameter int GAP_BITS = 0
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        send_en,
  input  logic [63:0] din,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        uart_txd
);

  localparam logic [3:0] GAP_LAST = gapLast(GAP_BITS);

  tx_state_t   r_state;
  logic        r_sendEnD;
  logic [63:0] r_shift;
  logic [2:0]  r_byteIdx;
  logic [2:0]  r_bitIdx;
  logic [3:0]  r_gapIdx;

  logic        w_sendEdge;
  logic        w_bitEnd;
  logic        w_baudClear;
  logic [7:0]  w_curByte;
  logic [2:0]  w_nextBitIdx;

  // The byte on the wire always sits in the top of the shift register
  assign w_curByte    = r_shift[63:56];
  assign w_nextBitIdx = r_bitIdx + 3'd1;
  assign w_sendEdge   = send_en & ~r_sendEnD;

  // Holding the timer cleared while idle makes every state start at count 0
  assign w_baudClear  = (r_state == S_IDLE);

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_baud (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .i_clear    (w_baudClear),
    .o_bitEnd   (w_bitEnd)
  );

  // Delayed copy of the request so only its rising edge starts a frame
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sendEnD <= 1'b0;
    end else begin
      r_sendEnD <= send_en;
    end
  end

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_byteIdx <= '0;
      r_bitIdx  <= '0;
      r_gapIdx  <= '0;
      uart_txd  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          uart_txd <= 1'b1;
          tx_busy  <= 1'b0;
          if (w_sendEdge) begin
            r_shift   <= din;
            r_byteIdx <= '0;
            r_bitIdx  <= '0;
            r_gapIdx  <= '0;
            uart_txd  <= 1'b0;
            tx_busy   <= 1'b1;
            r_state   <= S_START;
          end
        end

        S_START: begin
          if (w_bitEnd) begin
            r_bitIdx <= '0;
            uart_txd <= w_curByte[0];
            r_state  <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_bitEnd) begin
            if (r_bitIdx == 3'd7) begin
              uart_txd <= 1'b1;
              r_state  <= S_STOP;
            end else begin
              r_bitIdx <= w_nextBitIdx;
              uart_txd <= w_curByte[w_nextBitIdx];
            end
          end
        end

        S_STOP: begin
          if (w_bitEnd) begin
            if (r_byteIdx == LAST_BYTE) begin
              uart_txd <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_byteIdx <= r_byteIdx + 3'd1;
              r_bitIdx  <= '0;
              r_shift   <= {r_shift[55:0], 8'h00};
              if (GAP_BITS > 0) begin
                r_gapIdx <= '0;
                uart_txd <= 1'b1;
                r_state  <= S_GAP;
              end else begin
                uart_txd <= 1'b0;
                r_state  <= S_START;
              end
            end
          end
        end

        S_GAP: begin
          if (w_bitEnd) begin
            if (r_gapIdx == GAP_LAST) begin
              r_gapIdx <= '0;
              uart_txd <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_gapIdx <= r_gapIdx + 4'd1;
            end
          end
        end

        default: begin
          uart_txd <= 1'b1;
          tx_busy  <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame64.sv
// Directed bench for the 64-bit UART frame transmitter, run at a fast baud rate.
module tb_uart_tx_frame64;

  // 100 MHz / 9 MBd = 11.11, truncated to 11 clocks per bit
  localparam int N      = 11;
  localparam int FRAME0 = 880;   // 80 bit times, no gap
  localparam int FRAME2 = 1034;  // 80 + 7*2 bit times

  logic        clock = 1'b0;
  logic        cpuResetN;
  logic        sendEn;
  logic [63:0] din;

  logic txd1, busy1, done1;
  logic txd2, busy2, done2;
  logic sel;
  logic txdSel, busySel, doneSel;

  int assertCount = 0;
  int failCount   = 0;

  uart_tx_frame64 #(
    .CLK_FREQ (100_000_000),
    .UART_BPS (9_000_000),
    .GAP_BITS (0)
  ) dut (
    .CLK100MHZ  (clock),
    .CPU_RESETN (cpuResetN),
    .send_en    (sendEn),
    .din        (din),
    .tx_busy    (busy1),
    .tx_done    (done1),
    .uart_txd   (txd1)
  );

  uart_tx_frame64 #(
    .CLK_FREQ (100_000_000),
    .UART_BPS (9_000_000),
    .GAP_BITS (2)
  ) dutGap (
    .CLK100MHZ  (clock),
    .CPU_RESETN (cpuResetN),
    .send_en    (sendEn),
    .din        (din),
    .tx_busy    (busy2),
    .tx_done    (done2),
    .uart_txd   (txd2)
  );

  assign txdSel  = sel ? txd2  : txd1;
  assign busySel = sel ? busy2 : busy1;
  assign doneSel = sel ? done2 : done1;

  // 100 MHz system clock
  always #5 clock = ~clock;

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
    end
  endtask

  // One-cycle request pulse driven between clock edges
  task automatic applyStimulus(input logic [63:0] value);
    @(negedge clock);
    din    = value;
    sendEn = 1'b1;
    @(negedge clock);
    sendEn = 1'b0;
  endtask

  // Decode a whole frame, checking every cycle of every bit and gap
  task automatic captureFrame(input int gapBits, input int maxWait, output logic [63:0] data,
                              output int waitCycles, output int badCycles, output int doneSeen);
    logic [7:0] byteVal;
    logic       expBit;
    data       = '0;
    waitCycles = 0;
    badCycles  = 0;
    doneSeen   = 0;
    while (txdSel !== 1'b0 && waitCycles < maxWait) begin
      @(negedge clock);
      waitCycles++;
    end
    if (txdSel !== 1'b0) begin
      checkOutput("start_timeout", 64'(txdSel), 64'd0);
      waitCycles = -1;
      return;
    end
    for (int b = 0; b < 8; b++) begin
      byteVal = '0;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < N; c++) begin
          if (k == 0) begin
            expBit = 1'b0;
          end else if (k == 9) begin
            expBit = 1'b1;
          end else if (c == 0) begin
            byteVal[k-1] = txdSel;
            expBit       = txdSel;
          end else begin
            expBit = byteVal[k-1];
          end
          if (txdSel !== expBit) badCycles++;
          if (busySel !== 1'b1) badCycles++;
          if (doneSel !== 1'b0) doneSeen++;
          @(negedge clock);
        end
      end
      data = {data[55:0], byteVal};
      if (b < 7) begin
        for (int c = 0; c < gapBits * N; c++) begin
          if (txdSel !== 1'b1) badCycles++;
          if (busySel !== 1'b1) badCycles++;
          if (doneSel !== 1'b0) doneSeen++;
          @(negedge clock);
        end
      end
    end
  endtask

  // Count cycles in which the selected transmitter shows any activity
  task automatic watchIdle(input int cycles, output int activity);
    activity = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (txdSel !== 1'b1 || busySel !== 1'b0 || doneSel !== 1'b0) activity++;
    end
  endtask

  initial begin
    logic [63:0] data;
    int waitCycles, badCycles, doneSeen, activity, startCycle;

    sel       = 1'b0;
    cpuResetN = 1'b0;
    sendEn    = 1'b0;
    din       = '0;

    // Reset holds the line idle even while the request toggles
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      sendEn = ~sendEn;
      if (i % 2 == 1) begin
        checkOutput("rst_txd", 64'(txd1), 64'd1);
        checkOutput("rst_busy", 64'(busy1), 64'd0);
        checkOutput("rst_done", 64'(done1), 64'd0);
      end
    end
    sendEn = 1'b0;
    repeat (3) @(negedge clock);
    cpuResetN = 1'b1;
    watchIdle(5, activity);
    checkOutput("post_rst_idle", 64'(activity), 64'd0);

    // Single frame
    applyStimulus(64'h0123_4567_89AB_CDEF);
    captureFrame(0, 20, data, waitCycles, badCycles, doneSeen);
    checkOutput("s2_latency", 64'(waitCycles), 64'd0);
    checkOutput("s2_data", data, 64'h0123_4567_89AB_CDEF);
    checkOutput("s2_bit_timing", 64'(badCycles), 64'd0);
    checkOutput("s2_early_done", 64'(doneSeen), 64'd0);
    checkOutput("s2_done", 64'(txdSel && doneSel), 64'd1);
    checkOutput("s2_busy_end", 64'(busySel), 64'd0);
    watchIdle(50, activity);
    checkOutput("s2_after", 64'(activity), 64'd0);

    // Request during byte 3 is dropped
    applyStimulus(64'h0123_4567_89AB_CDEF);
    fork
      captureFrame(0, 20, data, waitCycles, badCycles, doneSeen);
      begin
        repeat (35 * N) @(negedge clock);
        din    = 64'hFFFF_FFFF_FFFF_FFFF;
        sendEn = 1'b1;
        @(negedge clock);
        sendEn = 1'b0;
      end
    join
    checkOutput("s3_data", data, 64'h0123_4567_89AB_CDEF);
    checkOutput("s3_bit_timing", 64'(badCycles), 64'd0);
    checkOutput("s3_early_done", 64'(doneSeen), 64'd0);
    checkOutput("s3_done", 64'(doneSel), 64'd1);
    watchIdle(2 * FRAME0, activity);
    checkOutput("s3_no_second", 64'(activity), 64'd0);

    // Level held high gives exactly one frame
    @(negedge clock);
    din    = 64'h1122_3344_5566_7788;
    sendEn = 1'b1;
    captureFrame(0, 20, data, waitCycles, badCycles, doneSeen);
    checkOutput("s4_level_data", data, 64'h1122_3344_5566_7788);
    checkOutput("s4_level_timing", 64'(badCycles), 64'd0);
    checkOutput("s4_level_done", 64'(doneSel), 64'd1);
    watchIdle(3000 - FRAME0, activity);
    checkOutput("s4_level_once", 64'(activity), 64'd0);
    sendEn = 1'b0;

    // Request in the done cycle starts the next frame one cycle later
    applyStimulus(64'hDEAD_BEEF_0F1E_2D3C);
    captureFrame(0, 20, data, waitCycles, badCycles, doneSeen);
    checkOutput("s4_first_data", data, 64'hDEAD_BEEF_0F1E_2D3C);
    checkOutput("s4_first_done", 64'(doneSel), 64'd1);
    din    = 64'h8001_4002_2004_1008;
    sendEn = 1'b1;
    captureFrame(0, 20, data, waitCycles, badCycles, doneSeen);
    checkOutput("s4_b2b_gap", 64'(waitCycles), 64'd1);
    checkOutput("s4_b2b_data", data, 64'h8001_4002_2004_1008);
    checkOutput("s4_b2b_timing", 64'(badCycles), 64'd0);
    checkOutput("s4_b2b_done", 64'(doneSel), 64'd1);
    sendEn = 1'b0;
    repeat (5) @(negedge clock);

    // Reset inside byte 4 abandons the frame at once
    applyStimulus(64'h0123_4567_89AB_CDEF);
    repeat (45 * N) @(negedge clock);
    checkOutput("s5_mid_busy", 64'(busySel), 64'd1);
    cpuResetN = 1'b0;
    #1;
    checkOutput("s5_rst_txd", 64'(txdSel), 64'd1);
    checkOutput("s5_rst_busy", 64'(busySel), 64'd0);
    din    = 64'hA5A5_A5A5_A5A5_A5A5;
    sendEn = 1'b1;
    watchIdle(20, activity);
    checkOutput("s5_rst_quiet", 64'(activity), 64'd0);
    cpuResetN = 1'b1;
    captureFrame(0, 20, data, waitCycles, badCycles, doneSeen);
    checkOutput("s5_data", data, 64'hA5A5_A5A5_A5A5_A5A5);
    checkOutput("s5_bit_timing", 64'(badCycles), 64'd0);
    checkOutput("s5_early_done", 64'(doneSeen), 64'd0);
    checkOutput("s5_done", 64'(doneSel), 64'd1);
    sendEn = 1'b0;

    // Two idle bit times between bytes
    repeat (400) @(negedge clock);
    sel = 1'b1;
    checkOutput("s6_idle_before", 64'(busySel), 64'd0);
    applyStimulus(64'h0123_4567_89AB_CDEF);
    startCycle = 0;
    captureFrame(2, 20, data, waitCycles, badCycles, doneSeen);
    checkOutput("s6_data", data, 64'h0123_4567_89AB_CDEF);
    checkOutput("s6_bit_timing", 64'(badCycles), 64'd0);
    checkOutput("s6_early_done", 64'(doneSeen), 64'd0);
    checkOutput("s6_done", 64'(doneSel), 64'd1);
    checkOutput("s6_busy_end", 64'(busySel), 64'd0);
    watchIdle(FRAME2, activity);
    checkOutput("s6_after", 64'(activity + startCycle), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
